// File: rtl/sequenciador_piscadas.sv
// rtl/sequenciador_piscadas.sv - timed LED blink sequencer: lit/dark phases repeated a fixed number of times
// Moore FSM: ACESO and APAGADO are timed by one shared 8-bit cycle counter.
module sequenciador_piscadas #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int BLINKS     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] padrao,
  input  logic       abortar,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       fim,
  output logic [3:0] piscadas,
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESO   = 2'd1,
    APAGADO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [7:0] ON_LAST  = 8'(ON_CYCLES - 1);
  localparam logic [7:0] OFF_LAST = 8'(OFF_CYCLES - 1);
  localparam logic [3:0] BLINKS_W = 4'(BLINKS);

  estado_t    estado, prox;
  logic [7:0] cnt, cnt_n;
  logic [3:0] pat, pat_n;
  logic [3:0] pisc_n;
  logic [3:0] pisc_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      cnt      <= 8'd0;
      pat      <= 4'd0;
      piscadas <= 4'd0;
    end else begin
      estado   <= prox;
      cnt      <= cnt_n;
      pat      <= pat_n;
      piscadas <= pisc_n;
    end
  end

  assign pisc_inc = piscadas + 4'd1;

  always_comb begin
    prox   = estado;
    cnt_n  = cnt;
    pat_n  = pat;
    pisc_n = piscadas;
    case (estado)
      OCIOSO: begin
        // abortar takes priority over a simultaneous start
        if (iniciar && !abortar) begin
          prox   = ACESO;
          pat_n  = padrao;
          cnt_n  = 8'd0;
          pisc_n = 4'd0;
        end
      end
      ACESO: begin
        if (abortar) begin
          prox = OCIOSO;
        end else if (cnt == ON_LAST) begin
          prox  = APAGADO;
          cnt_n = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      APAGADO: begin
        if (abortar) begin
          prox = OCIOSO;
        end else if (cnt == OFF_LAST) begin
          pisc_n = pisc_inc;
          cnt_n  = 8'd0;
          prox   = (pisc_inc == BLINKS_W) ? FIM : ACESO;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      FIM: begin
        prox = OCIOSO;
      end
      default: begin
        prox = OCIOSO;
      end
    endcase
  end

  always_comb begin
    leds      = (estado == ACESO) ? pat : 4'd0;
    ocupado   = (estado != OCIOSO);
    fim       = (estado == FIM);
    db_estado = estado;
  end

endmodule

// File: tb/tb_sequenciador_piscadas.sv
// tb/tb_sequenciador_piscadas.sv - scoreboard bench for sequenciador_piscadas
// Expected per-cycle outputs are queued by the stimulus; monitors pop and compare on the falling edge.
module tb_sequenciador_piscadas;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, abortar;
  logic [3:0] padrao;
  logic [3:0] leds, piscadas;
  logic       ocupado, fim;
  logic [1:0] db_estado;

  logic       ini2, abo2;
  logic [3:0] pad2;
  logic [3:0] leds2, pisc2;
  logic       ocup2, fim2;
  logic [1:0] est2;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic       ocup;
    logic       fim;
    logic [3:0] pisc;
    logic [1:0] est;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  exp_t em, em2;

  always #5 clock = ~clock;

  sequenciador_piscadas dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .padrao(padrao), .abortar(abortar),
    .leds(leds), .ocupado(ocupado), .fim(fim), .piscadas(piscadas), .db_estado(db_estado)
  );

  sequenciador_piscadas #(.ON_CYCLES(1), .OFF_CYCLES(1), .BLINKS(1)) dut2 (
    .clock(clock), .reset(reset), .iniciar(ini2), .padrao(pad2), .abortar(abo2),
    .leds(leds2), .ocupado(ocup2), .fim(fim2), .piscadas(pisc2), .db_estado(est2)
  );

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() != 0) begin
      em = q.pop_front();
      check("leds", int'(leds), int'(em.leds));
      check("ocupado", int'(ocupado), int'(em.ocup));
      check("fim", int'(fim), int'(em.fim));
      check("piscadas", int'(piscadas), int'(em.pisc));
      check("db_estado", int'(db_estado), int'(em.est));
    end
    if (q2.size() != 0) begin
      em2 = q2.pop_front();
      check("dut2 leds", int'(leds2), int'(em2.leds));
      check("dut2 ocupado", int'(ocup2), int'(em2.ocup));
      check("dut2 fim", int'(fim2), int'(em2.fim));
      check("dut2 piscadas", int'(pisc2), int'(em2.pisc));
      check("dut2 db_estado", int'(est2), int'(em2.est));
    end
  end

  // Default timing: cycle c (1..19) after the start edge; 4 lit + 2 dark per blink, FIM at 19
  function automatic exp_t exp_at(input int c, input logic [3:0] pat);
    exp_t e;
    int ph, b;
    ph = (c - 1) % 6;
    b  = (c - 1) / 6;
    if (c == 19)     e = '{leds: 4'd0, ocup: 1'b1, fim: 1'b1, pisc: 4'd3, est: 2'd3};
    else if (ph < 4) e = '{leds: pat, ocup: 1'b1, fim: 1'b0, pisc: 4'(b), est: 2'd1};
    else             e = '{leds: 4'd0, ocup: 1'b1, fim: 1'b0, pisc: 4'(b), est: 2'd2};
    return e;
  endfunction

  function automatic exp_t idle(input logic [3:0] p);
    exp_t e;
    e = '{leds: 4'd0, ocup: 1'b0, fim: 1'b0, pisc: p, est: 2'd0};
    return e;
  endfunction

  // Expected values describe the cycle just begun; inputs set here are sampled at its closing edge
  task automatic cyc(input logic i, input logic a, input logic [3:0] p, input exp_t e);
    @(posedge clock);
    #1;
    q.push_back(e);
    iniciar = i;
    abortar = a;
    padrao  = p;
  endtask

  task automatic cyc2(input logic i, input exp_t e);
    @(posedge clock);
    #1;
    q2.push_back(e);
    ini2 = i;
  endtask

  task automatic run_body(input logic [3:0] pat, input bit chg);
    for (int c = 1; c <= 19; c++)
      cyc(chg && (c == 8), 1'b0, (chg && c >= 3) ? 4'b0101 : pat, exp_at(c, pat));
  endtask

  task automatic full_run(input logic [3:0] pat, input bit chg, input logic [3:0] prev);
    cyc(1'b1, 1'b0, pat, idle(prev));
    run_body(pat, chg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; padrao = 4'd0;
    ini2 = 1'b0; abo2 = 1'b0; pad2 = 4'b1111;
    #1;
    check("reset leds", int'(leds), 0);
    check("reset ocupado", int'(ocupado), 0);
    check("reset fim", int'(fim), 0);
    check("reset piscadas", int'(piscadas), 0);
    check("reset db_estado", int'(db_estado), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    full_run(4'b1010, 1'b0, 4'd0);
    full_run(4'b1010, 1'b1, 4'd3);

    // Abort during the second lit phase
    cyc(1'b1, 1'b0, 4'b1010, idle(4'd3));
    for (int c = 1; c <= 8; c++)
      cyc(1'b0, c == 8, 4'b1010, exp_at(c, 4'b1010));
    cyc(1'b0, 1'b0, 4'b1010, idle(4'd1));

    // Simultaneous start and abort in OCIOSO
    cyc(1'b1, 1'b1, 4'b1111, idle(4'd1));
    cyc(1'b0, 1'b0, 4'b1111, idle(4'd1));

    full_run(4'b0000, 1'b0, 4'd1);

    // Asynchronous reset in the middle of the second dark phase
    cyc(1'b1, 1'b0, 4'b1100, idle(4'd3));
    for (int c = 1; c <= 11; c++)
      cyc(1'b0, 1'b0, 4'b1100, exp_at(c, 4'b1100));
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async reset db_estado", int'(db_estado), 0);
    check("async reset leds", int'(leds), 0);
    check("async reset piscadas", int'(piscadas), 0);
    check("async reset ocupado", int'(ocupado), 0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    iniciar = 1'b1;
    padrao  = 4'b0110;
    q.push_back(idle(4'd0));
    run_body(4'b0110, 1'b0);
    cyc(1'b0, 1'b0, 4'b0000, idle(4'd3));

    // Minimum-parameter instance: one blink of one lit and one dark cycle
    cyc2(1'b1, idle(4'd0));
    cyc2(1'b0, '{leds: 4'b1111, ocup: 1'b1, fim: 1'b0, pisc: 4'd0, est: 2'd1});
    cyc2(1'b0, '{leds: 4'b0000, ocup: 1'b1, fim: 1'b0, pisc: 4'd0, est: 2'd2});
    cyc2(1'b0, '{leds: 4'b0000, ocup: 1'b1, fim: 1'b1, pisc: 4'd1, est: 2'd3});
    cyc2(1'b0, idle(4'd1));

    @(posedge clock);
    @(posedge clock);
    check("scoreboard drained", q.size() + q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
